// File: rtl/cqu_mips_pkg.sv
// Shared types for the sram-like arbiter.
//   arb_state_t : arbiter FSM state (IDLE -> REQ -> RESP -> IDLE)
//   arb_owner_t : which channel owns the outstanding transaction
//   SIZE_*      : sram-like transfer size encodings
package cqu_mips_pkg;

   typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RESP} arb_state_t;
   typedef enum logic {OWN_INST, OWN_DATA} arb_owner_t;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// One sram-like channel.
//   master : drives req/wr/size/addr/wdata, receives rdata/addr_ok/data_ok
//   slave  : the opposite direction
interface sram_like_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) ();

   logic              req;
   logic              wr;
   logic [1:0]        size;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              addr_ok;
   logic              data_ok;

   modport master (
      output req, wr, size, addr, wdata,
      input  rdata, addr_ok, data_ok
   );

   modport slave (
      input  req, wr, size, addr, wdata,
      output rdata, addr_ok, data_ok
   );

endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like memory port between the inst and data channels.
// One transaction outstanding at a time; the response is routed back to
// the channel that issued it. Data wins ties unless inst has been passed
// over STARVE_LIMIT consecutive times while pending.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   inst_bus : inst channel (slave side)
//   data_bus : data channel (slave side)
//   mem_bus  : memory port (master side)
//   busy     : high whenever a transaction is in flight
module sram_like_arbiter
   import cqu_mips_pkg::*;
#(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   sram_like_arbiter_if.slave   inst_bus,
   sram_like_arbiter_if.slave   data_bus,
   sram_like_arbiter_if.master  mem_bus,
   output logic                 busy
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

   arb_state_t        r_state;
   arb_state_t        w_next_state;
   arb_owner_t        r_owner;
   logic [CNT_W-1:0]  r_starve_cnt;
   logic              r_wr;
   logic [1:0]        r_size;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;

   logic              w_any_req;
   logic              w_starved;
   arb_owner_t        w_winner;
   logic              w_grant;
   logic              w_resp_done;

   // Data wins unless inst is pending and has hit the starvation limit.
   function automatic arb_owner_t pick_winner(input logic inst_req,
                                              input logic data_req,
                                              input logic starved);
      return (data_req && !(inst_req && starved)) ? OWN_DATA : OWN_INST;
   endfunction

   assign w_any_req = inst_bus.req | data_bus.req;
   assign w_starved = (r_starve_cnt == LIMIT_C);
   assign w_winner  = pick_winner(inst_bus.req, data_bus.req, w_starved);
   assign w_grant   = (r_state == ARB_IDLE) && w_any_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ARB_IDLE;
         r_owner      <= OWN_INST;
         r_starve_cnt <= '0;
         r_wr         <= 1'b0;
         r_size       <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_grant) begin
            r_owner <= w_winner;
            if (w_winner == OWN_DATA) begin
               r_wr    <= data_bus.wr;
               r_size  <= data_bus.size;
               r_addr  <= data_bus.addr;
               r_wdata <= data_bus.wdata;
            end else begin
               r_wr    <= inst_bus.wr;
               r_size  <= inst_bus.size;
               r_addr  <= inst_bus.addr;
               r_wdata <= inst_bus.wdata;
            end
            // Count data grants that passed over a pending inst request.
            if (w_winner == OWN_DATA && inst_bus.req) begin
               if (!w_starved) r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end else begin
               r_starve_cnt <= '0;
            end
         end
      end
   end

   always_comb begin
      w_next_state     = r_state;
      inst_bus.addr_ok = 1'b0;
      data_bus.addr_ok = 1'b0;
      mem_bus.req      = 1'b0;
      w_resp_done      = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (w_any_req) begin
               if (w_winner == OWN_DATA) data_bus.addr_ok = 1'b1;
               else                      inst_bus.addr_ok = 1'b1;
               w_next_state = ARB_REQ;
            end
         end
         ARB_REQ: begin
            mem_bus.req = 1'b1;
            if (mem_bus.addr_ok) begin
               // Accept and response in the same cycle completes directly.
               if (mem_bus.data_ok) begin
                  w_resp_done  = 1'b1;
                  w_next_state = ARB_IDLE;
               end else begin
                  w_next_state = ARB_RESP;
               end
            end
         end
         ARB_RESP: begin
            if (mem_bus.data_ok) begin
               w_resp_done  = 1'b1;
               w_next_state = ARB_IDLE;
            end
         end
         default: w_next_state = ARB_IDLE;
      endcase
      inst_bus.data_ok = w_resp_done && (r_owner == OWN_INST);
      data_bus.data_ok = w_resp_done && (r_owner == OWN_DATA);
   end

   assign mem_bus.wr    = r_wr;
   assign mem_bus.size  = r_size;
   assign mem_bus.addr  = r_addr;
   assign mem_bus.wdata = r_wdata;

   assign inst_bus.rdata = mem_bus.rdata;
   assign data_bus.rdata = mem_bus.rdata;

   assign busy = (r_state != ARB_IDLE);

endmodule
